// File: rtl/instr_fetch.sv
// Instruction fetch: reads two bytes from a byte-wide ram and presents one big-endian instruction.
// Latency: instr_valid rises 2 cycles after entering FETCH_HI; peak throughput is 1 instruction per 3 cycles.
// Backpressure: a presented instruction is held in HOLD, with no ram reads, until instr_ready; a redirect flushes it.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   mem_rd_en           ram read enable (FETCH_HI / FETCH_LO only)
//   mem_rd_addr         ram read address (pc, or pc+1 for the lo byte)
//   mem_rd_data         ram read data, combinational from mem_rd_addr
//   instr_valid         instr / instr_pc hold a fetched instruction
//   instr_ready         decode accepts instr this cycle
//   instr, instr_pc     {hi byte @pc, lo byte @pc+1} and the address of the hi byte
//   redirect_en/_pc     load a new fetch address and flush the fetch in progress
//   pc                  current fetch PC (debug)
module instr_fetch #(
  parameter int                   ADDR_BITS = 8,
  parameter int                   DATA_BITS = 8,
  parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_rd_en,
  output logic [ADDR_BITS-1:0]   mem_rd_addr,
  input  logic [DATA_BITS-1:0]   mem_rd_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [2*DATA_BITS-1:0] instr,
  output logic [ADDR_BITS-1:0]   instr_pc,
  input  logic                   redirect_en,
  input  logic [ADDR_BITS-1:0]   redirect_pc,
  output logic [ADDR_BITS-1:0]   pc
);

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam logic [ADDR_BITS-1:0] PC_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] PC_TWO = ADDR_BITS'(2);

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [DATA_BITS-1:0]   hi_q, hi_d;
  logic [2*DATA_BITS-1:0] instr_q, instr_d;
  logic [ADDR_BITS-1:0]   instr_pc_q, instr_pc_d;
  logic                   valid_q, valid_d;

  // State and datapath registers; reset wins over redirect and normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH_HI;
      pc_q       <= RESET_PC;
      hi_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hi_q       <= hi_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hi_d        = hi_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    mem_rd_en   = 1'b0;
    mem_rd_addr = pc_q;

    unique case (state_q)
      FETCH_HI: begin
        mem_rd_en = 1'b1;
        hi_d      = mem_rd_data;
        state_d   = FETCH_LO;
      end
      FETCH_LO: begin
        // pc+1 and pc+2 wrap naturally in ADDR_BITS: pc=max reads lo from 0, next pc is 1.
        mem_rd_en   = 1'b1;
        mem_rd_addr = pc_q + PC_ONE;
        instr_d     = {hi_q, mem_rd_data};
        instr_pc_d  = pc_q;
        pc_d        = pc_q + PC_TWO;
        valid_d     = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        // HOLD is only entered with valid set; ready is qualified anyway so a
        // stray ready can never release an empty slot.
        if (valid_q && instr_ready) begin
          valid_d = 1'b0;
          state_d = FETCH_HI;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = FETCH_HI;
      end
    endcase

    // Redirect overrides the normal flow. A coincident handshake is simply
    // absorbed: valid drops either way. The presented instr/instr_pc are left
    // untouched so a redirect during FETCH_LO does not disturb them, and the
    // half-built hi byte is dropped.
    if (redirect_en) begin
      pc_d       = redirect_pc;
      valid_d    = 1'b0;
      state_d    = FETCH_HI;
      hi_d       = '0;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end

    if (reset) begin
      mem_rd_en = 1'b0;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        redirect_en;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;

  logic [7:0] ram [0:255];

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch #(
    .ADDR_BITS (8),
    .DATA_BITS (8),
    .RESET_PC  (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  // Combinational ram read, same cycle as the address.
  assign mem_rd_data = ram[mem_rd_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] i, input logic [7:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    sb.push_back(e);
  endtask

  // Waits (bounded) at negedges for instr_valid, then checks the next
  // scoreboard entry and, when exp_lat > 0, the number of cycles waited.
  task automatic wait_instr(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 20);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    e = sb.pop_front();
    chk({tag, "_instr"}, {16'd0, instr}, {16'd0, e.instr});
    chk({tag, "_pc"}, {24'd0, instr_pc}, {24'd0, e.pc});
    if (exp_lat > 0) chk({tag, "_lat"}, n, exp_lat);
  endtask

  // Leaves the bench at a negedge with reset just released.
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset       = 1'b1;
    redirect_en = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b0;
    instr_ready = rdy;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[8'h00] = 8'h12; ram[8'h01] = 8'h34;
    ram[8'h02] = 8'h56; ram[8'h03] = 8'h78;
    ram[8'h40] = 8'hAB; ram[8'h41] = 8'hCD;
    ram[8'hFF] = 8'h9A;

    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'h0);
    chk("rst_instr_pc", {24'd0, instr_pc}, 32'h0);
    chk("rst_pc", {24'd0, pc}, 32'h0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    reset       = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("t1_rd_en", {31'd0, mem_rd_en}, 32'd1);
    chk("t1_addr_hi", {24'd0, mem_rd_addr}, 32'h00);

    // 1: back-to-back fetch with ready held high
    push_exp(16'h1234, 8'h00);
    push_exp(16'h5678, 8'h02);
    wait_instr("t1_first", 2);
    wait_instr("t1_second", 3);

    // 2: backpressure holds the instruction and stops ram reads
    do_reset(1'b0);
    push_exp(16'h1234, 8'h00);
    wait_instr("t2_first", 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_hold_instr", {16'd0, instr}, 32'h1234);
      chk("t2_hold_rd_en", {31'd0, mem_rd_en}, 32'd0);
      chk("t2_hold_pc", {24'd0, pc}, 32'h02);
    end
    chk("t2_hold_instr_pc", {24'd0, instr_pc}, 32'h00);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t2_release_valid", {31'd0, instr_valid}, 32'd0);
    chk("t2_release_addr", {24'd0, mem_rd_addr}, 32'h02);
    push_exp(16'h5678, 8'h02);
    wait_instr("t2_second", 2);

    // 3: redirect during FETCH_LO flushes the partial fetch
    do_reset(1'b1);
    @(negedge clk);
    chk("t3_lo_addr", {24'd0, mem_rd_addr}, 32'h01);
    redirect_en = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect_en = 1'b0;
    chk("t3_valid", {31'd0, instr_valid}, 32'd0);
    chk("t3_pc", {24'd0, pc}, 32'h40);
    chk("t3_addr", {24'd0, mem_rd_addr}, 32'h40);
    push_exp(16'hABCD, 8'h40);
    wait_instr("t3_redir", 2);

    // 4: wrap-around fetch from 0xFF
    @(negedge clk);
    redirect_en = 1'b1;
    redirect_pc = 8'hFF;
    ram[8'h00]  = 8'hBC;
    @(negedge clk);
    redirect_en = 1'b0;
    chk("t4_addr_hi", {24'd0, mem_rd_addr}, 32'hFF);
    push_exp(16'h9ABC, 8'hFF);
    @(negedge clk);
    chk("t4_addr_lo", {24'd0, mem_rd_addr}, 32'h00);
    chk("t4_rd_en_lo", {31'd0, mem_rd_en}, 32'd1);
    wait_instr("t4_wrap", 1);
    chk("t4_next_pc", {24'd0, pc}, 32'h01);
    @(negedge clk);
    chk("t4_next_addr", {24'd0, mem_rd_addr}, 32'h01);
    chk("t4_next_rd_en", {31'd0, mem_rd_en}, 32'd1);

    // 5: redirect coincident with a HOLD handshake (odd pc fetch first)
    instr_ready = 1'b0;
    push_exp(16'h3456, 8'h01);
    wait_instr("t5_odd", 2);
    redirect_en = 1'b1;
    redirect_pc = 8'h02;
    instr_ready = 1'b1;
    @(negedge clk);
    redirect_en = 1'b0;
    instr_ready = 1'b0;
    chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_pc", {24'd0, pc}, 32'h02);
    push_exp(16'h5678, 8'h02);
    wait_instr("t5_redir", 2);

    // 6: reset in HOLD with a valid instruction
    reset = 1'b1;
    @(negedge clk);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_pc", {24'd0, pc}, 32'h00);
    chk("t6_instr", {16'd0, instr}, 32'h0);
    chk("t6_instr_pc", {24'd0, instr_pc}, 32'h00);
    chk("t6_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("t6_addr", {24'd0, mem_rd_addr}, 32'h00);
    @(negedge clk);
    chk("t6_rd_en2", {31'd0, mem_rd_en}, 32'd0);
    reset       = 1'b0;
    instr_ready = 1'b1;
    push_exp(16'hBC34, 8'h00);
    wait_instr("t6_after", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
